mem_port_arbiter: RTL

- Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store driven by the EX/MEM register's MemRead/MemWrite, ALU result and store data).
- Serialises both accesses, returns the read data and produces one stall signal that freezes PC, IF/ID, ID/EX and EX/MEM until every access pending this cycle has completed.
- A watchdog flags a memory that never acknowledges. A counter reports stall cycles for performance runs.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_watchdog.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned STALL_CNT_W = 32;

    // Saturating increment used by the stall performance counter
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog: counts cycles an access waits for ack and flags expiry.
module mem_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_c_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, otherwise count enabled cycles
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires on the TIMEOUT-th consecutive enabled cycle
    assign timeout_c_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one memory port
// and stalls the pipeline until every access of the current cycle is done.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   if_req_i,
    input  logic [ADDR_W-1:0]      if_addr_i,
    output logic [DATA_W-1:0]      if_data_o,
    input  logic                   d_read_i,
    input  logic                   d_write_i,
    input  logic [ADDR_W-1:0]      d_addr_i,
    input  logic [DATA_W-1:0]      d_wdata_i,
    output logic [DATA_W-1:0]      d_rdata_o,
    output logic                   stall_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    output logic                   err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    arb_state_e             state_q;
    logic                   d_done_q;
    logic                   i_done_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic [DATA_W-1:0]      if_data_q;
    logic [DATA_W-1:0]      d_rdata_q;
    logic                   err_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    logic need_d;
    logic need_i;
    logic stall_c;
    logic busy;
    logic wd_clr;
    logic wd_en;
    logic wd_timeout;

    // Outstanding work for the instruction pair currently in IF and MEM
    always_comb begin
        need_d  = (d_read_i | d_write_i) & ~d_done_q;
        need_i  = if_req_i & ~i_done_q;
        stall_c = need_d | need_i;
    end

    assign stall_o = stall_c;

    // Watchdog runs only while an access waits; any ack or idle cycle rearms it
    always_comb begin
        busy   = (state_q != ST_IDLE);
        wd_en  = busy & ~mem_ack_i;
        wd_clr = ~busy | mem_ack_i;
    end

    mem_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (wd_clr),
        .en_i        (wd_en),
        .timeout_c_o (wd_timeout)
    );

    // Arbiter FSM: data first (older instruction), fetch chained without a gap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            d_done_q    <= 1'b0;
            i_done_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            // Pipeline advances: next instruction's requests become visible
            if (!stall_c) begin
                d_done_q <= 1'b0;
                i_done_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (need_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_write_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_wdata_i;
                        state_q     <= ST_DATA;
                    end else if (need_i) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr_i;
                        state_q    <= ST_FETCH;
                    end
                end

                ST_DATA: begin
                    if (mem_ack_i) begin
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata_i;
                        end
                        d_done_q <= 1'b1;
                        if (need_i) begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= if_addr_i;
                            state_q    <= ST_FETCH;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end else if (wd_timeout) begin
                        err_q     <= 1'b1;
                        d_done_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                ST_FETCH: begin
                    if (mem_ack_i) begin
                        if_data_q <= mem_rdata_i;
                        i_done_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (wd_timeout) begin
                        err_q     <= 1'b1;
                        i_done_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall performance counter next value, saturating
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Stall performance counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
